// File: rtl/rom_stream_reader_if.sv
// rom_stream_reader_if: command, ROM-side and stream-side signals of the reader.
// master = reader side, slave = environment (command source, ROM, consumer).
interface rom_stream_reader_if #(
  parameter int AW = 3,
  parameter int DW = 3
);
  logic          start;
  logic [AW-1:0] base_adr;
  logic [AW:0]   count;
  logic          busy;
  logic          done;
  logic          rom_en;
  logic [AW-1:0] rom_adr;
  logic [DW-1:0] rom_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  modport master (
    input  start, base_adr, count,
    input  rom_data, out_ready,
    output busy, done,
    output rom_en, rom_adr,
    output out_valid, out_data, out_last
  );

  modport slave (
    output start, base_adr, count,
    output rom_data, out_ready,
    input  busy, done,
    input  rom_en, rom_adr,
    input  out_valid, out_data, out_last
  );
endinterface

// File: rtl/rom_stream_reader.sv
// rom_stream_reader: walks a ROM address range on start, streams words out.
// Ports: clk, rst (sync, active-high), bus (cmd / ROM / valid-ready stream).
module rom_stream_reader #(
  parameter int AW = 3,
  parameter int DW = 3
) (
  input  logic clk,
  input  logic rst,
  rom_stream_reader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] next_adr_q, next_adr_d;
  logic [AW-1:0] last_adr_q, last_adr_d;
  logic [AW:0]   issue_left_q, issue_left_d;
  logic [AW:0]   out_left_q, out_left_d;
  logic          inflight_q, inflight_d;
  logic          done_q, done_d;
  logic [DW-1:0] buf_q [2];
  logic [DW-1:0] buf_d [2];
  logic          rd_ptr_q, rd_ptr_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic [1:0]    occ_q, occ_d;

  logic          pop;
  logic          issue;
  logic [2:0]    used;
  logic [2:0]    limit;

  // A slot is promised to every word buffered or in flight; a pop this
  // cycle frees one, which keeps the 2-entry buffer from overflowing.
  always_comb begin
    pop   = (occ_q != 2'd0) & bus.out_ready;
    used  = {1'b0, occ_q} + {2'b00, inflight_q};
    limit = 3'd2 + {2'b00, pop};
    issue = (state_q == RUN) & (used < limit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    next_adr_d   = next_adr_q;
    last_adr_d   = last_adr_q;
    issue_left_d = issue_left_q;
    out_left_d   = out_left_q;
    inflight_d   = issue;
    done_d       = 1'b0;
    buf_d        = buf_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    occ_d        = occ_q + {1'b0, inflight_q} - {1'b0, pop};

    if (inflight_q) begin
      buf_d[wr_ptr_q] = bus.rom_data;
      wr_ptr_d        = ~wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d   = ~rd_ptr_q;
      out_left_d = out_left_q - (AW+1)'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.count != '0) begin
            state_d      = RUN;
            next_adr_d   = bus.base_adr;
            issue_left_d = bus.count;
            out_left_d   = bus.count;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (issue) begin
          next_adr_d   = next_adr_q + AW'(1);
          last_adr_d   = next_adr_q;
          issue_left_d = issue_left_q - (AW+1)'(1);
          if (issue_left_q == (AW+1)'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && out_left_q == (AW+1)'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Clearing inflight on reset drops the ROM word that returns afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      next_adr_q   <= '0;
      last_adr_q   <= '0;
      issue_left_q <= '0;
      out_left_q   <= '0;
      inflight_q   <= 1'b0;
      done_q       <= 1'b0;
      buf_q        <= '{default: '0};
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      occ_q        <= 2'd0;
    end else begin
      next_adr_q   <= next_adr_d;
      last_adr_q   <= last_adr_d;
      issue_left_q <= issue_left_d;
      out_left_q   <= out_left_d;
      inflight_q   <= inflight_d;
      done_q       <= done_d;
      buf_q        <= buf_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      occ_q        <= occ_d;
    end
  end

  // The address bus holds its last issued value between reads.
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.rom_en    = issue;
  assign bus.rom_adr   = issue ? next_adr_q : last_adr_q;
  assign bus.out_valid = (occ_q != 2'd0);
  assign bus.out_data  = buf_q[rd_ptr_q];
  assign bus.out_last  = bus.out_valid & (out_left_q == (AW+1)'(1));

endmodule
